// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and constants for the data-memory arbiter slice.
//   owner_e    : which requester a pending read response belongs to
//   STARVE_W   : width of the loader starvation counter (holds 0..15)
//   be_width() : byte-enable width for a given data width
//   DMEM_BE_W  : byte-enable width for the default 32-bit data path
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_LDR  = 1'b1
    } owner_e;

    localparam int STARVE_W = 4;
    localparam int DEF_DW   = 32;

    function automatic int be_width(input int dw);
        return dw / 8;
    endfunction

    localparam int DMEM_BE_W = be_width(DEF_DW);

endpackage

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles the two requester ports, the loader lock and the SRAM port of the
// data-memory arbiter.
//   master : requester/SRAM side (drives requests and SRAM read data)
//   slave  : arbiter side (drives grants, responses and the SRAM command)
// Parameters: AW byte address width, DW data width (byte enables are DW/8).
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    localparam int BW = DW / 8;

    logic          ldr_lock_i;

    logic          core_req_i;
    logic [BW-1:0] core_we_i;
    logic [AW-1:0] core_addr_i;
    logic [DW-1:0] core_wdata_i;
    logic          core_gnt_o;
    logic          core_rvalid_o;
    logic [DW-1:0] core_rdata_o;

    logic          ldr_req_i;
    logic [BW-1:0] ldr_we_i;
    logic [AW-1:0] ldr_addr_i;
    logic [DW-1:0] ldr_wdata_i;
    logic          ldr_gnt_o;
    logic          ldr_rvalid_o;
    logic [DW-1:0] ldr_rdata_o;

    logic          dmemen_o;
    logic [BW-1:0] dmemwe_o;
    logic [AW-1:0] dmemaddr_o;
    logic [DW-1:0] dmemdata_o;
    logic [DW-1:0] dmem_rdata_i;

    modport master (
        output ldr_lock_i,
        output core_req_i, core_we_i, core_addr_i, core_wdata_i,
        input  core_gnt_o, core_rvalid_o, core_rdata_o,
        output ldr_req_i, ldr_we_i, ldr_addr_i, ldr_wdata_i,
        input  ldr_gnt_o, ldr_rvalid_o, ldr_rdata_o,
        input  dmemen_o, dmemwe_o, dmemaddr_o, dmemdata_o,
        output dmem_rdata_i
    );

    modport slave (
        input  ldr_lock_i,
        input  core_req_i, core_we_i, core_addr_i, core_wdata_i,
        output core_gnt_o, core_rvalid_o, core_rdata_o,
        input  ldr_req_i, ldr_we_i, ldr_addr_i, ldr_wdata_i,
        output ldr_gnt_o, ldr_rvalid_o, ldr_rdata_o,
        output dmemen_o, dmemwe_o, dmemaddr_o, dmemdata_o,
        input  dmem_rdata_i
    );

endinterface

// File: rtl/dmem_arb_starve_cnt.sv
// -----------------------------------------------------------------------------
// dmem_arb_starve_cnt
// Counts consecutive core grants while the loader is waiting, saturating at
// STARVE_MAX. starve_hit tells the arbiter to hand the port to the loader.
//   clk, rstn  : clock, synchronous active-low reset
//   core_gnt   : core won the port this cycle
//   ldr_req    : loader is requesting
//   ldr_gnt    : loader won the port this cycle
//   lock       : loader owns the port exclusively (no starvation possible)
//   starve_hit : counter has reached STARVE_MAX
// -----------------------------------------------------------------------------
module dmem_arb_starve_cnt
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic core_gnt,
    input  logic ldr_req,
    input  logic ldr_gnt,
    input  logic lock,
    output logic starve_hit
);

    localparam logic [STARVE_W-1:0] CNT_MAX = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] cnt_reg;
    logic [STARVE_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        // Any cycle where the loader is served, not waiting, or locked in
        // restarts the count of core wins it has sat through.
        if (ldr_gnt || !ldr_req || lock) begin
            cnt_next = '0;
        end else if (core_gnt && (cnt_reg != CNT_MAX)) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign starve_hit = (cnt_reg == CNT_MAX);

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one synchronous-SRAM data port between the core pipeline and the
// boot/debug loader. Core has fixed priority; after STARVE_MAX consecutive
// core wins over a waiting loader, the loader is forced through. Read data
// (one cycle after the enabled read) is steered back to the issuing side.
//   clk_i  : clock
//   rstn_i : synchronous active-low reset
//   bus    : requester ports, loader lock and SRAM port (slave modport)
// Parameters: AW address width, DW data width, STARVE_MAX (1..15).
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    dmem_arbiter_if.slave   bus
);

    localparam int BW = DW / 8;

    logic   core_gnt;
    logic   ldr_gnt;
    logic   starve_hit;

    logic   rsp_valid_reg;
    logic   rsp_valid_next;
    owner_e rsp_owner_reg;
    owner_e rsp_owner_next;

    dmem_arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_cnt (
        .clk        (clk_i),
        .rstn       (rstn_i),
        .core_gnt   (core_gnt),
        .ldr_req    (bus.ldr_req_i),
        .ldr_gnt    (ldr_gnt),
        .lock       (bus.ldr_lock_i),
        .starve_hit (starve_hit)
    );

    // Grant decision, highest priority first.
    always_comb begin
        core_gnt = 1'b0;
        ldr_gnt  = 1'b0;
        if (bus.ldr_lock_i) begin
            ldr_gnt = bus.ldr_req_i;
        end else if (bus.ldr_req_i && starve_hit) begin
            ldr_gnt = 1'b1;
        end else if (bus.core_req_i) begin
            core_gnt = 1'b1;
        end else if (bus.ldr_req_i) begin
            ldr_gnt = 1'b1;
        end
    end

    assign bus.core_gnt_o = core_gnt;
    assign bus.ldr_gnt_o  = ldr_gnt;
    assign bus.dmemen_o   = core_gnt | ldr_gnt;

    // SRAM command mux, one byte lane at a time. Grants are one-hot, so an
    // AND-OR mux yields zero on every lane when nobody is granted.
    genvar gi;
    generate
        for (gi = 0; gi < BW; gi++) begin : g_lane
            assign bus.dmemwe_o[gi] = (core_gnt & bus.core_we_i[gi])
                                    | (ldr_gnt  & bus.ldr_we_i[gi]);
            assign bus.dmemdata_o[gi*8 +: 8] =
                  ({8{core_gnt}} & bus.core_wdata_i[gi*8 +: 8])
                | ({8{ldr_gnt}}  & bus.ldr_wdata_i[gi*8 +: 8]);
        end
    endgenerate

    assign bus.dmemaddr_o = ({AW{core_gnt}} & bus.core_addr_i)
                          | ({AW{ldr_gnt}}  & bus.ldr_addr_i);

    // A granted access with no byte enables is a read; remember who issued
    // it so the SRAM data next cycle goes back to the right side.
    always_comb begin
        rsp_valid_next = (core_gnt && (bus.core_we_i == '0))
                      || (ldr_gnt  && (bus.ldr_we_i  == '0));
        rsp_owner_next = rsp_owner_reg;
        if (rsp_valid_next) begin
            rsp_owner_next = ldr_gnt ? OWN_LDR : OWN_CORE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            rsp_valid_reg <= 1'b0;
            rsp_owner_reg <= OWN_CORE;
        end else begin
            rsp_valid_reg <= rsp_valid_next;
            rsp_owner_reg <= rsp_owner_next;
        end
    end

    logic core_rsp;
    logic ldr_rsp;

    assign core_rsp = rsp_valid_reg && (rsp_owner_reg == OWN_CORE);
    assign ldr_rsp  = rsp_valid_reg && (rsp_owner_reg == OWN_LDR);

    assign bus.core_rvalid_o = core_rsp;
    assign bus.ldr_rvalid_o  = ldr_rsp;
    assign bus.core_rdata_o  = core_rsp ? bus.dmem_rdata_i : '0;
    assign bus.ldr_rdata_o   = ldr_rsp  ? bus.dmem_rdata_i : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed scenarios followed by randomized traffic, every cycle compared
// against a transaction-level model of the arbitration rules.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int SM = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    dmem_arbiter #(
        .AW         (AW),
        .DW         (DW),
        .STARVE_MAX (SM)
    ) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model state: loader wait length in core wins, and who (if anyone)
    // gets read data this cycle: 0 nobody, 1 core, 2 loader.
    int m_wait = 0;
    int m_pend = 0;
    bit m_cg   = 1'b0;
    bit m_lg   = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_core(input bit req, input logic [BW-1:0] we,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        bus.core_req_i   = req;
        bus.core_we_i    = we;
        bus.core_addr_i  = addr;
        bus.core_wdata_i = wd;
    endtask

    task automatic set_ldr(input bit req, input logic [BW-1:0] we,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        bus.ldr_req_i   = req;
        bus.ldr_we_i    = we;
        bus.ldr_addr_i  = addr;
        bus.ldr_wdata_i = wd;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance
    // the model with the inputs seen at the rising edge.
    task automatic cycle();
        bit cg;
        bit lg;
        logic [BW-1:0] e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        @(negedge clk);
        cg = 1'b0;
        lg = 1'b0;
        if (bus.ldr_lock_i)                     lg = bus.ldr_req_i;
        else if (bus.ldr_req_i && m_wait >= SM) lg = 1'b1;
        else if (bus.core_req_i)                cg = 1'b1;
        else if (bus.ldr_req_i)                 lg = 1'b1;
        e_we   = cg ? bus.core_we_i    : (lg ? bus.ldr_we_i    : '0);
        e_addr = cg ? bus.core_addr_i  : (lg ? bus.ldr_addr_i  : '0);
        e_data = cg ? bus.core_wdata_i : (lg ? bus.ldr_wdata_i : '0);
        chk("core_gnt",    64'(bus.core_gnt_o),    64'(cg));
        chk("ldr_gnt",     64'(bus.ldr_gnt_o),     64'(lg));
        chk("dmemen",      64'(bus.dmemen_o),      64'(cg | lg));
        chk("dmemwe",      64'(bus.dmemwe_o),      64'(e_we));
        chk("dmemaddr",    64'(bus.dmemaddr_o),    64'(e_addr));
        chk("dmemdata",    64'(bus.dmemdata_o),    64'(e_data));
        chk("core_rvalid", 64'(bus.core_rvalid_o), 64'(m_pend == 1));
        chk("core_rdata",  64'(bus.core_rdata_o),  (m_pend == 1) ? 64'(bus.dmem_rdata_i) : 64'd0);
        chk("ldr_rvalid",  64'(bus.ldr_rvalid_o),  64'(m_pend == 2));
        chk("ldr_rdata",   64'(bus.ldr_rdata_o),   (m_pend == 2) ? 64'(bus.dmem_rdata_i) : 64'd0);
        $display("t=%0t rstn=%0b lock=%0b creq=%0b lreq=%0b gnt=%s%s addr=%h we=%h rv=%0d rdata=%h",
                 $time, rstn, bus.ldr_lock_i, bus.core_req_i, bus.ldr_req_i,
                 cg ? "C" : "-", lg ? "L" : "-", bus.dmemaddr_o, bus.dmemwe_o,
                 m_pend, bus.dmem_rdata_i);
        @(posedge clk);
        if (!rstn) begin
            m_wait = 0;
            m_pend = 0;
        end else begin
            if (cg && bus.core_we_i == '0)     m_pend = 1;
            else if (lg && bus.ldr_we_i == '0) m_pend = 2;
            else                               m_pend = 0;
            if (lg || !bus.ldr_req_i || bus.ldr_lock_i) m_wait = 0;
            else if (cg && m_wait < SM)                 m_wait = m_wait + 1;
        end
        m_cg = cg;
        m_lg = lg;
        #1;
    endtask

    initial begin
        string pat;
        bus.ldr_lock_i   = 1'b0;
        bus.dmem_rdata_i = '0;
        set_core(1'b0, '0, '0, '0);
        set_ldr(1'b0, '0, '0, '0);
        #1;

        // Reset: no requests, everything quiet.
        rstn = 1'b0;
        cycle();
        cycle();
        chk("reset_core_rvalid", 64'(bus.core_rvalid_o), 64'd0);
        rstn = 1'b1;

        // Core read of 0x10, SRAM returns DEADBEEF next cycle.
        set_core(1'b1, 4'b0000, 32'h10, 32'h0);
        cycle();
        set_core(1'b0, '0, '0, '0);
        bus.dmem_rdata_i = 32'hDEADBEEF;
        cycle();

        // Core store: completes in its grant cycle, no response.
        set_core(1'b1, 4'b0011, 32'h20, 32'h0000ABCD);
        cycle();
        set_core(1'b0, '0, '0, '0);
        bus.dmem_rdata_i = 32'h12345678;
        cycle();

        // Continuous contention: expect C,C,C,C,L,C,C,C,C,L.
        set_core(1'b1, 4'b1111, 32'h100, 32'h1);
        set_ldr(1'b1, 4'b1111, 32'h200, 32'h2);
        pat = "";
        for (int i = 0; i < 10; i++) begin
            cycle();
            pat = {pat, m_cg ? "C" : (m_lg ? "L" : "-")};
        end
        checks++;
        assert (pat == "CCCCLCCCCL")
        else begin
            errors++;
            $error("FAIL starve_pattern: observed %s expected CCCCLCCCCL", pat);
        end

        // Lock: loader only, then core granted the cycle the lock drops.
        bus.ldr_lock_i = 1'b1;
        for (int i = 0; i < 6; i++) cycle();
        bus.ldr_lock_i = 1'b0;
        cycle();
        chk("unlock_core_gnt", 64'(m_cg), 64'd1);
        set_core(1'b0, '0, '0, '0);
        set_ldr(1'b0, '0, '0, '0);
        cycle();

        // Read granted during the reset cycle never responds.
        set_core(1'b1, 4'b0000, 32'h40, 32'h0);
        rstn = 1'b0;
        bus.dmem_rdata_i = 32'hCAFEF00D;
        cycle();
        set_core(1'b0, '0, '0, '0);
        cycle();
        rstn = 1'b1;
        cycle();

        // Back-to-back reads: core at 0x0 then loader at 0x4.
        set_core(1'b1, 4'b0000, 32'h0, 32'h0);
        cycle();
        set_core(1'b0, '0, '0, '0);
        set_ldr(1'b1, 4'b0000, 32'h4, 32'h0);
        bus.dmem_rdata_i = 32'hAAAA0000;
        cycle();
        set_ldr(1'b0, '0, '0, '0);
        bus.dmem_rdata_i = 32'hBBBB0004;
        cycle();
        cycle();

        // Random traffic; requesters hold their fields until granted.
        for (int i = 0; i < 400; i++) begin
            if (!(bus.core_req_i && !m_cg))
                set_core($urandom_range(0, 2) != 0,
                         ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'b0000,
                         $urandom, $urandom);
            if (!(bus.ldr_req_i && !m_lg))
                set_ldr($urandom_range(0, 1) != 0,
                        ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'b0000,
                        $urandom, $urandom);
            bus.ldr_lock_i   = ($urandom_range(0, 9) == 0);
            rstn             = ($urandom_range(0, 39) != 0);
            bus.dmem_rdata_i = $urandom;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
